// File: rtl/fp_wb_writer.sv
// fp_wb_writer -- write-back front end for the RV32F floating-point register file.
//
// Merges results from two producers (channel A: pipelined FPU, channel B:
// iterative div/sqrt) with round-robin arbitration. It buffers them in order
// in a small FIFO and drives the single register-file write port with at most
// one write per cycle. A pending-destination mask tells hazard logic which
// f-registers still have a write in flight.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data   channel A result handshake and payload
//   b_valid/b_ready/b_rd/b_data   channel B result handshake and payload
//   fp_reg_write, rd, wb_data     registered register-file write port
//   pend_mask               bit r set while a buffered or output entry targets f[r]
//   fifo_count              current FIFO occupancy, 0..DEPTH
//
// Build option: define FP_WB_BYPASS_EN so that an entry accepted while the
// FIFO is empty goes straight to the output registers (1-edge latency).
// Without it, every entry goes through the FIFO (2-edge latency).

module fp_wb_writer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic             fp_reg_write,
    output logic [4:0]       rd,
    output logic [31:0]      wb_data,
    output logic [31:0]      pend_mask,
    output logic [PTR_W:0]   fifo_count
);

    localparam logic           GRANT_A    = 1'b0;
    localparam logic           GRANT_B    = 1'b1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             last_grant_r;

    logic             full_s;
    logic             a_fire_s;
    logic             b_fire_s;
    logic             acc_s;
    logic [4:0]       acc_rd_s;
    logic [31:0]      acc_data_s;
    logic             pop_s;
    logic             bypass_s;
    logic             push_s;
    logic [PTR_W-1:0] slot_off_s;

    assign fifo_count = count_r;
    assign full_s     = (count_r == FULL_COUNT);

    // Readies depend only on registered state and the other channel's valid.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (full_s) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end else begin
            a_ready = !b_valid || (last_grant_r == GRANT_B);
            b_ready = !a_valid || (last_grant_r == GRANT_A);
        end
    end

    assign a_fire_s = a_valid && a_ready;
    assign b_fire_s = b_valid && b_ready;
    assign acc_s    = a_fire_s || b_fire_s;
    assign pop_s    = (count_r != {(PTR_W + 1){1'b0}});

    // Select the accepted payload; the two fires are mutually exclusive.
    always_comb begin
        acc_rd_s   = 5'd0;
        acc_data_s = 32'd0;
        if (a_fire_s) begin
            acc_rd_s   = a_rd;
            acc_data_s = a_data;
        end else begin
            acc_rd_s   = b_rd;
            acc_data_s = b_data;
        end
    end

`ifdef FP_WB_BYPASS_EN
    // An empty FIFO lets the accepted entry skip the buffer.
    assign bypass_s = acc_s && !pop_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = acc_s && !bypass_s;

    // FIFO storage; contents need no reset because count gates validity.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            rd_mem[wr_ptr_r]   <= acc_rd_s;
            data_mem[wr_ptr_r] <= acc_data_s;
        end
    end

    // Pointers, occupancy, arbitration history and the registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            last_grant_r <= GRANT_B;
            fp_reg_write <= 1'b0;
            rd           <= 5'd0;
            wb_data      <= 32'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end

            if (pop_s) begin
                fp_reg_write <= 1'b1;
                rd           <= rd_mem[rd_ptr_r];
                wb_data      <= data_mem[rd_ptr_r];
                rd_ptr_r     <= rd_ptr_r + PTR_W'(1);
            end else if (bypass_s) begin
                fp_reg_write <= 1'b1;
                rd           <= acc_rd_s;
                wb_data      <= acc_data_s;
            end else begin
                fp_reg_write <= 1'b0;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase

            if (a_fire_s) begin
                last_grant_r <= GRANT_A;
            end else if (b_fire_s) begin
                last_grant_r <= GRANT_B;
            end
        end
    end

    // Pending mask: a slot is live when its distance from rd_ptr is below count;
    // the entry currently on the write port is still in flight too.
    always_comb begin
        pend_mask  = 32'd0;
        slot_off_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off_s = PTR_W'(i) - rd_ptr_r;
            if ({1'b0, slot_off_s} < count_r) begin
                pend_mask = pend_mask | (32'd1 << rd_mem[i]);
            end else begin
                pend_mask = pend_mask;
            end
        end
        if (fp_reg_write) begin
            pend_mask = pend_mask | (32'd1 << rd);
        end else begin
            pend_mask = pend_mask;
        end
    end

endmodule

// File: tb/tb_fp_wb_writer.sv
// tb_fp_wb_writer -- self-checking bench for fp_wb_writer.
// The reference model is a queue of accepted {rd, data} entries plus the
// expected write-port registers. It is updated once per clock edge from the
// arbitration, FIFO and bypass rules. Honours FP_WB_BYPASS_EN like the design.

module tb_fp_wb_writer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        fp_reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [36:0] q[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_lg_b;
    int          n_accepted;

    // Observed register file and commit log, built from DUT outputs.
    logic [31:0] rf_obs [32];
    logic [4:0]  commits[$];
    logic [31:0] commit_data[$];

    fp_wb_writer #(.DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .fp_reg_write(fp_reg_write), .rd(rd), .wb_data(wb_data),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = 32'd0;
        foreach (q[i]) m[q[i][36:32]] = 1'b1;
        if (m_we) m[m_rd] = 1'b1;
        return m;
    endfunction

    // One clock cycle: inputs already driven; called just after a negedge.
    task automatic step();
        logic        full, ra, rb, fa, fb, took;
        logic [36:0] acc;
        #1;
        full = (q.size() == DEPTH);
        ra = !full && (!b_valid || m_lg_b);
        rb = !full && (!a_valid || !m_lg_b);
        check("a_ready", {31'd0, a_ready}, {31'd0, ra});
        check("b_ready", {31'd0, b_ready}, {31'd0, rb});
        fa = a_valid && ra;
        fb = b_valid && rb && !fa;
        acc = fa ? {a_rd, a_data} : {b_rd, b_data};
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_lg_b = 1'b1;
        end else begin
            took = 1'b0;
            if (fa || fb) n_accepted++;
            if (q.size() > 0) begin
                {m_rd, m_data} = q.pop_front();
                m_we = 1'b1;
            end
`ifdef FP_WB_BYPASS_EN
            else if (fa || fb) begin
                {m_rd, m_data} = acc;
                m_we = 1'b1;
                took = 1'b1;
            end
`endif
            else m_we = 1'b0;
            if ((fa || fb) && !took) q.push_back(acc);
            if (fa) m_lg_b = 1'b0;
            else if (fb) m_lg_b = 1'b1;
        end
        #1;
        check("fp_reg_write", {31'd0, fp_reg_write}, {31'd0, m_we});
        check("rd", {27'd0, rd}, {27'd0, m_rd});
        check("wb_data", wb_data, m_data);
        check("pend_mask", pend_mask, model_pend());
        check("fifo_count", {29'd0, fifo_count}, q.size());
        if (fp_reg_write) begin
            rf_obs[rd] = wb_data;
            commits.push_back(rd);
            commit_data.push_back(wb_data);
        end
        if (fa) a_valid = 1'b0;
        if (fb) b_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [4:0] exp_order [8];
        int         ai, bi, budget;

        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_rd = 5'd0; b_rd = 5'd0; a_data = 32'd0; b_data = 32'd0;
        m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_lg_b = 1'b1;
        n_accepted = 0;
        foreach (rf_obs[i]) rf_obs[i] = 32'd0;
        @(negedge clock);
        idle(2);
        reset = 1'b0;
        check("reset_a_ready", {31'd0, a_ready}, 32'd1);

        // Single A write to f5.
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h3F80_0000;
        step();
        check("single_pend5", {31'd0, pend_mask[5]}, 32'd1);
        idle(3);
        check("single_f5", rf_obs[5], 32'h3F80_0000);

        // Contention: alternating grants starting with A after reset.
        reset = 1'b1; idle(1); reset = 1'b0;
        commits.delete();
        ai = 0; bi = 0;
        while (ai < 4 || bi < 4) begin
            if (!a_valid && ai < 4) begin a_valid = 1'b1; a_rd = 5'(1 + ai); a_data = 32'(100 + ai); ai++; end
            if (!b_valid && bi < 4) begin b_valid = 1'b1; b_rd = 5'(11 + bi); b_data = 32'(200 + bi); bi++; end
            step();
        end
        while (a_valid || b_valid) step();
        idle(3);
        exp_order = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        check("contend_count", commits.size(), 32'd8);
        for (int i = 0; i < 8 && i < commits.size(); i++)
            check("contend_order", {27'd0, commits[i]}, {27'd0, exp_order[i]});

        // Same-rd ordering: A f7=1.0 then B f7=2.0.
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h3F80_0000;
        step();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h4000_0000;
        step();
        idle(3);
        check("same_rd_f7", rf_obs[7], 32'h4000_0000);
        check("same_rd_pend7", {31'd0, pend_mask[7]}, 32'd0);

        // Wrap-around: 10 back-to-back A pushes.
        commits.delete(); commit_data.delete();
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_rd = 5'(i + 16); a_data = 32'(32'hA000 + i);
            step();
        end
        idle(3);
        check("wrap_count", commits.size(), 32'd10);
        for (int i = 0; i < 10 && i < commit_data.size(); i++)
            check("wrap_data", commit_data[i], 32'(32'hA000 + i));

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_rd = 5'(i + 20); a_data = 32'(i + 1);
            step();
        end
        a_valid = 1'b1; a_rd = 5'd23; a_data = 32'd9;
        reset = 1'b1; step(); reset = 1'b0; a_valid = 1'b0;
        check("rst_we", {31'd0, fp_reg_write}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_pend", pend_mask, 32'd0);
        check("rst_a_ready", {31'd0, a_ready}, 32'd1);
        commits.delete();
        idle(3);
        check("rst_no_stale", commits.size(), 32'd0);

        // Random traffic: 100 accepted writes, producers hold until accepted.
        commits.delete();
        n_accepted = 0;
        budget = 0;
        while (n_accepted < 100 && budget < 3000) begin
            if (!a_valid && ($urandom_range(0, 3) != 0) && n_accepted < 100) begin
                a_valid = 1'b1; a_rd = 5'($urandom); a_data = $urandom;
            end
            if (!b_valid && ($urandom_range(0, 2) == 0) && n_accepted < 99) begin
                b_valid = 1'b1; b_rd = 5'($urandom); b_data = $urandom;
            end
            step();
            budget++;
        end
        check("random_budget", {31'd0, (budget < 3000)}, 32'd1);
        a_valid = 1'b0; b_valid = 1'b0;
        idle(4);
        check("random_commits", commits.size(), n_accepted);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
